// File: rtl/spart_pkg.sv
// spart_pkg: constants and receiver state encoding shared by the SPART transmitter, receiver and top level
package spart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS = 8;
  localparam logic [1:0] IOADDR_DATA = 2'b00;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/spart_rx_bitclk.sv
// spart_rx_bitclk: oversample tick counter and data bit counter for the receiver
module spart_rx_bitclk
  import spart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic mid_bit,
  output logic bit_done,
  output logic last_bit
);
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  // counters advance only on baud ticks; clr parks both at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      tick_cnt <= tick_cnt + 4'd1;
      if (bit_done) bit_cnt <= bit_cnt + 3'd1;
    end
  assign mid_bit = en && tick_cnt == 4'(OVERSAMPLE / 2 - 1);
  assign bit_done = en && tick_cnt == 4'(OVERSAMPLE - 1);
  assign last_bit = bit_cnt == 3'(DATA_BITS - 1);
endmodule

// File: rtl/spart_rx.sv
// spart_rx: 8N1 serial receiver with holding register and rda/ferr/ovr flags; SPART_RX_SYNC_EN adds an rxd synchroniser
module spart_rx
  import spart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_r_enable,
  input  logic                 rxd,
  input  logic                 rd_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 ferr,
  output logic                 ovr
);
  rx_state_t state, state_nxt;
  logic rxd_s, mid_bit, bit_done, last_bit, clr, shift_en, load, frame_err;
  logic [DATA_BITS-1:0] shift;
`ifdef SPART_RX_SYNC_EN
  logic [1:0] sync;
  // two-flop synchroniser, resets high so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rxd};
  assign rxd_s = sync[1];
`else
  assign rxd_s = rxd;
`endif
  spart_rx_bitclk u_bitclk (
    .clk      (clk),
    .rst      (rst),
    .en       (baud_r_enable),
    .clr      (clr),
    .mid_bit  (mid_bit),
    .bit_done (bit_done),
    .last_bit (last_bit)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RX_IDLE;
    else state <= state_nxt;
  // frame sequencing, evaluated only on baud ticks
  always_comb begin
    state_nxt = state;
    if (baud_r_enable)
      case (state)
        RX_IDLE:  if (!rxd_s) state_nxt = RX_START;
        RX_START: if (mid_bit) state_nxt = rxd_s ? RX_IDLE : RX_DATA;
        RX_DATA:  if (bit_done && last_bit) state_nxt = RX_STOP;
        default:  if (bit_done) state_nxt = RX_IDLE;
      endcase
  end
  // per-state control strobes for the counters and datapath
  always_comb begin
    clr = state == RX_IDLE || (state == RX_START && mid_bit);
    shift_en = state == RX_DATA && bit_done;
    load = state == RX_STOP && bit_done && rxd_s;
    frame_err = state == RX_STOP && bit_done && !rxd_s;
  end
  // shift register, holding register and sticky flags; a load beats a simultaneous read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shift <= '0;
      rx_data <= '0;
      rda <= 1'b0;
      ferr <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (shift_en) shift <= {rxd_s, shift[DATA_BITS-1:1]};
      if (load) rx_data <= shift;
      rda <= load || (rda && !rd_strobe);
      ferr <= frame_err || (ferr && !rd_strobe);
      ovr <= !rd_strobe && (ovr || (load && rda));
    end
endmodule
